uart_echo_checker: RTL
======================

# uart_echo_checker

Self-test initiator for the board's UART echo path: transmits a sequence of bytes on its TX pin, receives the responder's reply on its RX pin, and checks each reply equals the sent byte plus one (mod 256). It sits on the far side of the serial link, either in a second FPGA or on spare pins looped to the responder. Pass, error and timeout counts are exposed for LEDs or debug.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- BIT_RATE, 115200, serial bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide, must be ≥ 4)
- NUM_BYTES, 256, bytes per test run (1..65535)
- FIRST_BYTE, 8'h00, first byte sent; byte i = (FIRST_BYTE + i) mod 256
- TIMEOUT_BITS, 40, reply timeout in bit periods
- clk_in  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse begins a run; ignored while busy
- uart_rxd  input  1  serial in from responder TX (asynchronous)
- uart_txd  output  1  serial out to responder RX, 8N1, LSB first
- busy  output  1  high from the cycle after accepted start until the run ends
- done  output  1  high after a run completes, cleared by next accepted start
- pass_cnt  output  16  replies matching expected
- err_cnt  output  16  replies mismatching or with framing error
- timeout_cnt  output  16  bytes with no reply in time
- last_rx  output  8  most recent received byte

## Operation
- FSM states: IDLE, SEND, WAIT, CHECK, DONE.
- IDLE: start → clear counters and done, load byte index 0, go SEND.
- SEND: serialize current byte: start bit (0), 8 data bits LSB first, stop bit (1); each bit held exactly CYCLES_PER_BIT cycles. After stop bit period → WAIT, load timeout counter with TIMEOUT_BITS*CYCLES_PER_BIT.
- WAIT: complete RX frame → CHECK; timeout counter reaches 0 → timeout_cnt++, advance.
- CHECK (one cycle): expected = (sent + 1)[7:0], so 0xFF expects 0x00. Match and stop bit 1 → pass_cnt++; otherwise err_cnt++. Advance.
- Advance: index == NUM_BYTES-1 → DONE, else index++ and SEND.
- DONE: assert done, deassert busy, next cycle IDLE (done held).
- RX deserializer runs continuously: 2-FF synchronizer, falling edge arms frame, sample at CYCLES_PER_BIT/2 into start bit; start bit high there → abort (glitch). Data sampled at bit centres, then stop bit. Frames completing outside WAIT are discarded (last_rx still updates).
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: uart_txd=1, busy=0, done=0, all counters 0, last_rx=0, FSM IDLE, RX idle.
- Reset mid-frame: uart_txd returns to 1 asynchronously; partial RX frame dropped.
- start accepted in IDLE only; busy rises next cycle; start bit begins that same cycle.
- Frame = 10*CYCLES_PER_BIT cycles on uart_txd; next byte's start bit begins 1 cycle after CHECK or timeout.
- RX latency: frame-valid asserts 2 sync cycles + sampling point of stop bit after its falling edge; CHECK occurs the next cycle.
- Frame completing in the same cycle the timeout expires: treated as reply (CHECK), no timeout.
- Fixed run length with no timeouts: NUM_BYTES*(10*CYCLES_PER_BIT + reply latency + 1) cycles.

## Structure
- Package uart_pkg: state enum, DATA_BITS=8, frame constants (START=0, STOP=1), shared with existing UART blocks.
- Sub-module uart_echo_deser: synchronizer, mid-bit sampler, emits data[7:0], valid pulse, frame_err. TX serializer and FSM in the top module.

## Test plan
- CLK_HZ=16, BIT_RATE=1, NUM_BYTES=4, bench model returns byte+1 → pass_cnt=4, err_cnt=0, timeout_cnt=0, done=1.
- Same, model returns byte unchanged (wire loopback) → err_cnt=4, pass_cnt=0.
- uart_rxd tied high → timeout_cnt=4, done after 4*(10+40)*16 + ~4 cycles.
- FIRST_BYTE=8'hFE, NUM_BYTES=2, +1 model → sends FE, FF; replies FF, 00; pass_cnt=2, last_rx=00.
- +1 model but reply stop bit 0 on second byte → pass_cnt=3, err_cnt=1; start pulse while busy → no restart.
- rst asserted during byte 2 data bits → uart_txd=1 immediately, counters 0, busy=0; new start runs cleanly to pass_cnt=4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, checker/deserializer state encodings
// and a saturating counter helper.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_echo_deser.sv
// Free-running 8N1 receiver: two-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling. Emits a one-cycle valid with the byte and a framing flag.
module uart_echo_deser
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int HALF  = CYCLES_PER_BIT / 2;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);

    logic [1:0]           r_sync;
    logic                 r_prev;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_rx;
    logic                 w_fall;

    assign w_rx   = r_sync[1];
    assign w_fall = r_prev & ~w_rx;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // Synchronizer resets to the idle-high line level so reset release is not a falling edge.
            r_sync      <= 2'b11;
            r_prev      <= 1'b1;
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rxd};
            r_prev  <= w_rx;
            o_valid <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= (w_rx == FRAME_START) ? RX_DATA : RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'(DATA_BITS - 1)) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
                        r_cnt       <= '0;
                        r_state     <= RX_IDLE;
                        o_valid     <= 1'b1;
                        o_data      <= r_shift;
                        o_frame_err <= (w_rx != FRAME_STOP);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_checker.sv
// Echo-path self-test initiator: sends a byte sequence, expects each reply to be
// the sent byte plus one, and counts passes, errors and timeouts.
module uart_echo_checker
    import uart_pkg::*;
#(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         BIT_RATE     = 115200,
    parameter int         NUM_BYTES    = 256,
    parameter logic [7:0] FIRST_BYTE   = 8'h00,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] timeout_cnt,
    output logic [7:0]  last_rx
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int TMO_CYCLES     = TIMEOUT_BITS * CYCLES_PER_BIT;
    localparam int CYC_W          = $clog2(CYCLES_PER_BIT);
    localparam int TMO_W          = $clog2(TMO_CYCLES + 1);

    state_t           r_state;
    logic [15:0]      r_idx;
    logic [3:0]       r_bit;
    logic [CYC_W-1:0] r_cyc;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_rx_byte;
    logic             r_rx_ferr;

    logic [7:0] w_tx_byte;
    logic [7:0] w_expect;
    logic       w_last;
    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_rx_ferr;

    assign w_tx_byte = FIRST_BYTE + r_idx[7:0];
    assign w_expect  = w_tx_byte + 8'd1;
    assign w_last    = (r_idx == 16'(NUM_BYTES - 1));

    uart_echo_deser #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_deser (
        .i_clk      (clk_in),
        .i_rst      (rst),
        .i_rxd      (uart_rxd),
        .o_data     (w_rx_data),
        .o_valid    (w_rx_valid),
        .o_frame_err(w_rx_ferr)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            uart_txd    <= FRAME_STOP;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            err_cnt     <= '0;
            timeout_cnt <= '0;
            last_rx     <= '0;
            r_idx       <= '0;
            r_bit       <= '0;
            r_cyc       <= '0;
            r_tmo       <= '0;
            r_rx_byte   <= '0;
            r_rx_ferr   <= 1'b0;
        end else begin
            if (w_rx_valid) begin
                last_rx <= w_rx_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        pass_cnt    <= '0;
                        err_cnt     <= '0;
                        timeout_cnt <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        r_idx       <= '0;
                        r_bit       <= '0;
                        r_cyc       <= '0;
                        uart_txd    <= FRAME_START;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_cyc == CYC_W'(CYCLES_PER_BIT - 1)) begin
                        r_cyc <= '0;
                        if (r_bit == 4'(DATA_BITS + 1)) begin
                            r_tmo   <= TMO_W'(TMO_CYCLES);
                            r_state <= ST_WAIT;
                        end else begin
                            r_bit    <= r_bit + 1'b1;
                            uart_txd <= (r_bit == 4'(DATA_BITS)) ? FRAME_STOP : w_tx_byte[r_bit[2:0]];
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A reply landing on the expiry cycle wins over the timeout.
                    if (w_rx_valid) begin
                        r_rx_byte <= w_rx_data;
                        r_rx_ferr <= w_rx_ferr;
                        r_state   <= ST_CHECK;
                    end else if (r_tmo == '0) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                        if (w_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx    <= r_idx + 16'd1;
                            r_bit    <= '0;
                            r_cyc    <= '0;
                            uart_txd <= FRAME_START;
                            r_state  <= ST_SEND;
                        end
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_rx_byte == w_expect && !r_rx_ferr) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end else begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx    <= r_idx + 16'd1;
                        r_bit    <= '0;
                        r_cyc    <= '0;
                        uart_txd <= FRAME_START;
                        r_state  <= ST_SEND;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
